// File: rtl/codec_cfg_pkg.sv
// Shared types for the codec configuration sequencer:
// state codes, the delay-entry marker and the table entry layout.
package codec_cfg_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_BOOT     = 4'd0;
    localparam state_t ST_FETCH    = 4'd1;
    localparam state_t ST_LOAD     = 4'd2;
    localparam state_t ST_ISSUE    = 4'd3;
    localparam state_t ST_WAIT_RSP = 4'd4;
    localparam state_t ST_GAP      = 4'd5;
    localparam state_t ST_DELAY    = 4'd6;
    localparam state_t ST_DONE     = 4'd7;
    localparam state_t ST_ERROR    = 4'd8;

    // A table entry with this register address is a pause, not a write.
    localparam logic [15:0] DELAY_ADDR = 16'hFFFF;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } cfg_entry_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/codec_cfg_seq_if.sv
// Config ROM read port and I2C transaction request/response bundle.
// master: the sequencer. slave: the ROM + I2C transaction master side.
interface codec_cfg_seq_if #(
    parameter int AW = 5
);

    logic [AW-1:0] rom_addr;
    logic [23:0]   rom_data;
    logic          txn_valid;
    logic          txn_ready;
    logic [6:0]    txn_dev;
    logic [15:0]   txn_addr;
    logic [7:0]    txn_data;
    logic          rsp_valid;
    logic          rsp_nack;

    modport master (
        output rom_addr,
        input  rom_data,
        output txn_valid,
        input  txn_ready,
        output txn_dev,
        output txn_addr,
        output txn_data,
        input  rsp_valid,
        input  rsp_nack
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  txn_valid,
        output txn_ready,
        input  txn_dev,
        input  txn_addr,
        input  txn_data,
        output rsp_valid,
        output rsp_nack
    );

endinterface

// File: rtl/cfg_down_counter.sv
// Loadable down counter with a zero flag; one instance times boot,
// retry gap and delay entries. Ports: clk, rst_n, load, en, load_val, zero.
module cfg_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/codec_cfg_seq.sv
// Walks the ADAU1761 register table and issues each write to the I2C
// transaction master, with boot wait, delay entries and NACK retry.
// Ports: clk_i, rst_n, start_i, bus (ROM + txn master side),
//        busy_o, done_o, err_o, err_idx_o.
module codec_cfg_seq
    import codec_cfg_pkg::*;
#(
    parameter logic [6:0] dev_addr_p    = 7'h3B,
    parameter int         num_cmds_p    = 32,
    parameter int         boot_cycles_p = 1024,
    parameter int         max_retries_p = 3,
    parameter int         retry_gap_p   = 256,
    parameter int         delay_unit_p  = 1024,
    localparam int AW = (num_cmds_p > 1) ? $clog2(num_cmds_p) : 1
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              start_i,
    codec_cfg_seq_if.master   bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [AW-1:0]     err_idx_o
);

    localparam int RW =
        (max_retries_p > 0) ? $clog2(max_retries_p + 1) : 1;
    localparam int DW = 8 + $clog2(delay_unit_p);
    localparam int CW = max3($clog2(boot_cycles_p),
                             $clog2(retry_gap_p), DW);

    state_t        state;
    logic [AW-1:0] idx;
    logic [RW-1:0] retries;
    cfg_entry_t    entry;
    logic          boot_arm;

    cfg_entry_t    rom_entry;
    logic [DW-1:0] dly_prod;
    logic          is_dly;
    logic          dly_zero;
    logic          is_last;
    logic          retry_ok;
    logic          step_done;

    logic          tmr_load;
    logic          tmr_en;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;

    assign rom_entry = cfg_entry_t'(bus.rom_data);
    assign is_dly    = (rom_entry.addr == DELAY_ADDR);
    assign dly_zero  = (rom_entry.data == 8'h00);
    assign dly_prod  = DW'(rom_entry.data) * DW'(delay_unit_p);
    assign is_last   = (idx == AW'(num_cmds_p - 1));
    assign retry_ok  = (retries < RW'(max_retries_p));

    // Entry finished: write ACKed, zero-length delay, or delay expired.
    assign step_done =
        ((state == ST_LOAD) && is_dly && dly_zero) ||
        ((state == ST_WAIT_RSP) && bus.rsp_valid && !bus.rsp_nack) ||
        ((state == ST_DELAY) && tmr_zero);

    // Timed states load N-1 on entry and leave when the count hits zero.
    always_comb begin
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = '0;
        unique case (state)
            ST_BOOT: begin
                if (!boot_arm) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(boot_cycles_p - 1);
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_LOAD: begin
                if (is_dly && !dly_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(dly_prod - 1'b1);
                end
            end
            ST_WAIT_RSP: begin
                if (bus.rsp_valid && bus.rsp_nack && retry_ok) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(retry_gap_p - 1);
                end
            end
            ST_GAP, ST_DELAY: tmr_en = 1'b1;
            default: ;
        endcase
    end

    cfg_down_counter #(
        .W (CW)
    ) u_tmr (
        .clk      (clk_i),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // boot_arm spends one cycle loading the timer, since the counter
    // itself comes out of reset at zero.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            idx      <= '0;
            retries  <= '0;
            entry    <= '0;
            boot_arm <= 1'b0;
        end else begin
            unique case (state)
                ST_BOOT: begin
                    if (!boot_arm) begin
                        boot_arm <= 1'b1;
                    end else if (tmr_zero) begin
                        boot_arm <= 1'b0;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_LOAD;
                ST_LOAD: begin
                    entry <= rom_entry;
                    if (!is_dly) begin
                        state <= ST_ISSUE;
                    end else if (!dly_zero) begin
                        state <= ST_DELAY;
                    end
                end
                ST_ISSUE: begin
                    if (bus.txn_ready) begin
                        state <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (bus.rsp_valid) begin
                        if (!bus.rsp_nack) begin
                            retries <= '0;
                        end else if (retry_ok) begin
                            retries <= retries + 1'b1;
                            state   <= ST_GAP;
                        end else begin
                            state <= ST_ERROR;
                        end
                    end
                end
                ST_GAP: begin
                    if (tmr_zero) begin
                        state <= ST_ISSUE;
                    end
                end
                ST_DELAY: ;
                ST_DONE, ST_ERROR: begin
                    if (start_i) begin
                        state    <= ST_BOOT;
                        idx      <= '0;
                        retries  <= '0;
                        boot_arm <= 1'b0;
                    end
                end
                default: state <= ST_BOOT;
            endcase

            // No wrap: the last entry ends the sequence.
            if (step_done) begin
                if (is_last) begin
                    state <= ST_DONE;
                end else begin
                    idx   <= idx + 1'b1;
                    state <= ST_FETCH;
                end
            end
        end
    end

    assign bus.rom_addr  = idx;
    assign bus.txn_valid = (state == ST_ISSUE);
    assign bus.txn_dev   = dev_addr_p;
    assign bus.txn_addr  = entry.addr;
    assign bus.txn_data  = entry.data;

    assign done_o    = (state == ST_DONE);
    assign err_o     = (state == ST_ERROR);
    assign busy_o    = !(done_o || err_o);
    assign err_idx_o = err_o ? idx : '0;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Bench for codec_cfg_seq: 4-entry table, ROM and I2C master models,
// directed ACK/NACK/error/delay/backpressure/reset/restart scenarios.
module tb_codec_cfg_seq;

    localparam int AW = 2;

    logic          clk_i   = 1'b0;
    logic          rst_n   = 1'b1;
    logic          start_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [AW-1:0] err_idx_o;

    codec_cfg_seq_if #(.AW(AW)) bus ();

    codec_cfg_seq #(
        .num_cmds_p   (4),
        .delay_unit_p (16)
    ) dut (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .bus       (bus),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .err_idx_o (err_idx_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    logic [23:0] rom_tbl [4];
    int          nack_plan  [4];
    int          nack_given [4];
    int          ready_hold = 0;
    int          rsp_lat    = 4;

    logic [15:0] acc_addr [$];
    logic [7:0]  acc_data [$];
    logic [6:0]  acc_dev  [$];
    int          acc_cyc  [$];
    int          rsp_cyc  [$];
    int          stable_bad = 0;

    int cyc        = 0;
    int both_cnt   = 0;
    int hs_cnt     = 0;
    int err_valid  = 0;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (done_o && err_o) both_cnt <= both_cnt + 1;
        if (bus.txn_valid && bus.txn_ready) hs_cnt <= hs_cnt + 1;
        if (err_o && bus.txn_valid) err_valid <= err_valid + 1;
    end

    // Table ROM: data valid one cycle after the address.
    always @(posedge clk_i) bus.rom_data <= rom_tbl[bus.rom_addr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [31:0] acc_word(input int i);
        if (i < acc_addr.size())
            return {8'h00, acc_addr[i], acc_data[i]};
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int acc_at(input int i);
        return (i < acc_cyc.size()) ? acc_cyc[i] : 0;
    endfunction

    function automatic int rsp_at(input int i);
        return (i < rsp_cyc.size()) ? rsp_cyc[i] : 0;
    endfunction

    // I2C transaction master model.
    initial begin : slave
        logic [15:0] a;
        logic [7:0]  d;
        int          e;
        logic        nk;
        logic        abort;
        bus.txn_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_nack  = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            if (rst_n && bus.txn_valid) begin
                a = bus.txn_addr;
                d = bus.txn_data;
                for (int k = 0; k < ready_hold; k++) begin
                    @(posedge clk_i); #1;
                    if (bus.txn_addr !== a || bus.txn_data !== d ||
                        bus.txn_valid !== 1'b1)
                        stable_bad++;
                end
                acc_dev.push_back(bus.txn_dev);
                bus.txn_ready = 1'b1;
                @(posedge clk_i); #1;
                bus.txn_ready = 1'b0;
                acc_addr.push_back(a);
                acc_data.push_back(d);
                acc_cyc.push_back(cyc);
                if (bus.txn_valid !== 1'b0) stable_bad++;
                e = 0;
                for (int j = 0; j < 4; j++)
                    if (rom_tbl[j][23:8] == a) e = j;
                abort = 1'b0;
                for (int k = 0; k < rsp_lat; k++) begin
                    @(posedge clk_i); #1;
                    if (!rst_n) abort = 1'b1;
                end
                if (!abort && rst_n) begin
                    nk = (nack_given[e] < nack_plan[e]);
                    if (nk) nack_given[e]++;
                    bus.rsp_valid = 1'b1;
                    bus.rsp_nack  = nk;
                    rsp_cyc.push_back(cyc);
                    @(posedge clk_i); #1;
                    bus.rsp_valid = 1'b0;
                    bus.rsp_nack  = 1'b0;
                end
            end
        end
    end

    task automatic wait_end(input int lim);
        int n = 0;
        while (!(done_o || err_o) && n < lim) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("end_reached", 32'(done_o || err_o), 1);
    endtask

    task automatic wait_acc(input int target, input int lim);
        int n = 0;
        while (acc_addr.size() < target && n < lim) begin
            @(posedge clk_i); #2;
            n++;
        end
        chk("acc_reached", 32'(acc_addr.size()), 32'(target));
    endtask

    task automatic pulse_start();
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
    endtask

    initial begin : main
        int ab;
        int rb;
        int s0;
        int h0;
        int ev0;
        int gap;
        int ord [6];

        rom_tbl[0] = 24'h4000_01;
        rom_tbl[1] = 24'h4015_01;
        rom_tbl[2] = 24'h4016_02;
        rom_tbl[3] = 24'h40F9_7F;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_busy", 32'(busy_o), 1);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_valid", 32'(bus.txn_valid), 0);
        chk("rst_err_idx", 32'(err_idx_o), 0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);
        rst_n = 1'b1;

        // All ACK; start pulse while busy must be ignored.
        ab = acc_addr.size();
        wait_acc(ab + 2, 3000);
        pulse_start();
        wait_end(5000);
        chk("A_done", 32'(done_o), 1);
        chk("A_busy", 32'(busy_o), 0);
        chk("A_err", 32'(err_o), 0);
        chk("A_count", 32'(acc_addr.size() - ab), 4);
        for (int k = 0; k < 4; k++)
            chk("A_entry", acc_word(ab + k), {8'h00, rom_tbl[k]});
        chk("A_dev", 32'(acc_dev[ab]), 32'h3B);

        // Restart from DONE; entry1 NACKs twice then ACKs.
        ab = acc_addr.size();
        rb = rsp_cyc.size();
        nack_plan[1] = nack_given[1] + 2;
        pulse_start();
        chk("B_restart_busy", 32'(busy_o), 1);
        chk("B_restart_done", 32'(done_o), 0);
        wait_end(5000);
        chk("B_done", 32'(done_o), 1);
        chk("B_count", 32'(acc_addr.size() - ab), 6);
        ord = '{0, 1, 1, 1, 2, 3};
        for (int k = 0; k < 6; k++)
            chk("B_order", acc_word(ab + k), {8'h00, rom_tbl[ord[k]]});
        gap = acc_at(ab + 2) - rsp_at(rb + 1);
        chk("B_gap1", 32'(gap >= 256 && gap <= 270), 1);
        gap = acc_at(ab + 3) - rsp_at(rb + 2);
        chk("B_gap2", 32'(gap >= 256 && gap <= 270), 1);

        // Entry2 NACKs four times: retries exhausted.
        ab = acc_addr.size();
        nack_plan[2] = nack_given[2] + 4;
        pulse_start();
        wait_end(6000);
        chk("C_err", 32'(err_o), 1);
        chk("C_done", 32'(done_o), 0);
        chk("C_busy", 32'(busy_o), 0);
        chk("C_err_idx", 32'(err_idx_o), 2);
        chk("C_count", 32'(acc_addr.size() - ab), 6);
        chk("C_last", acc_word(ab + 5), {8'h00, rom_tbl[2]});
        ev0 = err_valid;
        repeat (400) @(posedge clk_i);
        #1;
        chk("C_quiet", 32'(acc_addr.size() - ab), 6);
        chk("C_no_valid", 32'(err_valid - ev0), 0);
        chk("C_err_hold", 32'(err_o), 1);

        // Restart from ERROR; entry2 is a 3-unit delay, slow ready.
        rom_tbl[2] = 24'hFFFF_03;
        ready_hold = 10;
        ab = acc_addr.size();
        rb = rsp_cyc.size();
        s0 = stable_bad;
        h0 = hs_cnt;
        pulse_start();
        chk("D_err_clr", 32'(err_o), 0);
        chk("D_busy", 32'(busy_o), 1);
        wait_end(5000);
        chk("D_done", 32'(done_o), 1);
        chk("D_count", 32'(acc_addr.size() - ab), 3);
        chk("D_e0", acc_word(ab), {8'h00, rom_tbl[0]});
        chk("D_e1", acc_word(ab + 1), {8'h00, rom_tbl[1]});
        chk("D_e3", acc_word(ab + 2), {8'h00, rom_tbl[3]});
        gap = acc_at(ab + 2) - rsp_at(rb + 1);
        chk("D_delay_gap", 32'(gap >= 58 && gap <= 68), 1);
        chk("D_stable", 32'(stable_bad - s0), 0);
        chk("D_one_accept", 32'(hs_cnt - h0), 3);

        // Reset while waiting for entry1's response.
        rom_tbl[2] = 24'h4016_02;
        ready_hold = 0;
        rsp_lat = 20;
        ab = acc_addr.size();
        pulse_start();
        wait_acc(ab + 2, 3000);
        @(posedge clk_i);
        #1 rst_n = 1'b0;
        #1;
        chk("E_rst_busy", 32'(busy_o), 1);
        chk("E_rst_valid", 32'(bus.txn_valid), 0);
        chk("E_rst_done", 32'(done_o), 0);
        chk("E_rst_rom_addr", 32'(bus.rom_addr), 0);
        repeat (3) @(posedge clk_i);
        #1 rst_n = 1'b1;
        rsp_lat = 4;
        ab = acc_addr.size();
        wait_end(5000);
        chk("E_done", 32'(done_o), 1);
        chk("E_count", 32'(acc_addr.size() - ab), 4);
        chk("E_first", acc_word(ab), {8'h00, rom_tbl[0]});

        chk("done_err_excl", 32'(both_cnt), 0);
        chk("payload_stable", 32'(stable_bad), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
